// File: rtl/mult8_if.sv
// Operand/control bundle and register taps of the shift-add multiplier datapath.
// Optional step counter ports exist only when MULT8_STEP_CNT_EN is defined.
interface mult8_if;
    logic [7:0] S;
    logic       Ld_B;
    logic       Clear_A;
    logic       Ld_A;
    logic       Shift_En;
    logic       select_op;
    logic       M;
    logic [7:0] Aval;
    logic [7:0] Bval;
    logic       X;
`ifdef MULT8_STEP_CNT_EN
    logic [3:0] Step_Cnt;
    logic       Done;

    modport master (
        output S, Ld_B, Clear_A, Ld_A, Shift_En, select_op,
        input  M, Aval, Bval, X, Step_Cnt, Done
    );

    modport slave (
        input  S, Ld_B, Clear_A, Ld_A, Shift_En, select_op,
        output M, Aval, Bval, X, Step_Cnt, Done
    );
`else
    modport master (
        output S, Ld_B, Clear_A, Ld_A, Shift_En, select_op,
        input  M, Aval, Bval, X
    );

    modport slave (
        input  S, Ld_B, Clear_A, Ld_A, Shift_En, select_op,
        output M, Aval, Bval, X
    );
`endif
endinterface

// File: rtl/mult8_datapath.sv
// X:A:B register datapath of an 8x8 signed shift-add multiplier (sequencing is external).
// Define MULT8_STEP_CNT_EN to add the Step_Cnt/Done shift counter.
module mult8_datapath (
    input  logic     Clk,
    input  logic     Reset,
    mult8_if.slave   bus
);

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned SUM_W   = DATA_W + 1;

    logic              x_q, x_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [SUM_W-1:0]  sum;

    // Sign-extended add/subtract of S into A; carry out of bit 8 is dropped.
    always_comb begin
        sum = {a_q[DATA_W-1], a_q}
            + ({bus.S[DATA_W-1], bus.S} ^ {SUM_W{bus.select_op}})
            + SUM_W'(bus.select_op);
    end

    // Next-state selection; B shift always uses the pre-update A[0].
    always_comb begin
        x_d = x_q;
        a_d = a_q;
        b_d = b_q;

        if (bus.Clear_A) begin
            x_d = 1'b0;
            a_d = '0;
        end else if (bus.Ld_A) begin
            if (b_q[0]) begin
                x_d = sum[SUM_W-1];
                a_d = sum[DATA_W-1:0];
            end
        end else if (bus.Shift_En) begin
            a_d = {x_q, a_q[DATA_W-1:1]};
        end

        if (bus.Ld_B) begin
            b_d = bus.S;
        end else if (bus.Shift_En) begin
            b_d = {a_q[0], b_q[DATA_W-1:1]};
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            x_q <= 1'b0;
            a_q <= '0;
            b_q <= '0;
        end else begin
            x_q <= x_d;
            a_q <= a_d;
            b_q <= b_d;
        end
    end

    assign bus.M    = b_q[0];
    assign bus.X    = x_q;
    assign bus.Aval = a_q;
    assign bus.Bval = b_q;

`ifdef MULT8_STEP_CNT_EN
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned N_STEPS = 8;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q;

    // Counts shifts since the last clear, holding at N_STEPS.
    always_comb begin
        cnt_d = cnt_q;
        if (bus.Clear_A) begin
            cnt_d = '0;
        end else if (bus.Shift_En && (cnt_q != CNT_W'(N_STEPS))) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= (cnt_d == CNT_W'(N_STEPS));
        end
    end

    assign bus.Step_Cnt = cnt_q;
    assign bus.Done     = done_q;
`endif

endmodule

// File: tb/tb_mult8_datapath.sv
// Directed bench for mult8_datapath; compares {X, Aval, Bval} against hand-computed values.
module tb_mult8_datapath;

    logic Clk;
    logic Reset;
    int   total;
    int   bad;

    mult8_if bus ();

    mult8_datapath dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] s, input logic ld_b, input logic clr,
                         input logic ld_a, input logic sh, input logic op);
        bus.S         = s;
        bus.Ld_B      = ld_b;
        bus.Clear_A   = clr;
        bus.Ld_A      = ld_a;
        bus.Shift_En  = sh;
        bus.select_op = op;
    endtask

    // Leaves A=a_val (via add of a_val with M=1 from cleared A) and B=b_val; b_val[0] must be 1.
    task automatic preset(input logic [7:0] a_val, input logic [7:0] b_val);
        drive(b_val, 1, 0, 0, 0, 0); tick();
        drive(8'h00, 0, 1, 0, 0, 0); tick();
        drive(a_val, 0, 0, 1, 0, 0); tick();
        drive(8'h00, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        drive(8'hAA, 1, 1, 1, 1, 1);
        tick();
        total++;
        if ({bus.X, bus.Aval, bus.Bval} !== 17'h0_0000) begin
            bad++;
            $display("FAIL reset_all_ctrl got %h want %h", {bus.X, bus.Aval, bus.Bval}, 17'h0_0000);
        end
        total++;
        if (bus.M !== 1'b0) begin
            bad++;
            $display("FAIL reset_m got %b want 0", bus.M);
        end
`ifdef MULT8_STEP_CNT_EN
        total++;
        if ({bus.Step_Cnt, bus.Done} !== 5'b0000_0) begin
            bad++;
            $display("FAIL reset_cnt got %h want 00", {bus.Step_Cnt, bus.Done});
        end
`endif
        Reset = 1'b1;
        drive(8'h00, 0, 0, 0, 0, 0);
    endtask

    task automatic test_add_sub();
        drive(8'h01, 1, 0, 0, 0, 0); tick();
        drive(8'h00, 0, 1, 0, 0, 0); tick();
        drive(8'h05, 0, 0, 1, 0, 0); tick();
        total++;
        if ({bus.X, bus.Aval} !== 9'h005) begin
            bad++;
            $display("FAIL add_5 got %h want %h", {bus.X, bus.Aval}, 9'h005);
        end
        drive(8'h00, 0, 1, 0, 0, 0); tick();
        drive(8'h05, 0, 0, 1, 0, 1); tick();
        total++;
        if ({bus.X, bus.Aval, bus.M} !== 10'b1_1111_1011_1) begin
            bad++;
            $display("FAIL sub_5 got %h want %h", {bus.X, bus.Aval, bus.M}, 10'b1_1111_1011_1);
        end
        drive(8'h00, 0, 0, 0, 0, 0);
    endtask

    task automatic test_shift();
        drive(8'h00, 0, 0, 0, 1, 0); tick();
        total++;
        if ({bus.X, bus.Aval, bus.Bval} !== {1'b1, 8'hFD, 8'h80}) begin
            bad++;
            $display("FAIL shift got %h want %h", {bus.X, bus.Aval, bus.Bval}, {1'b1, 8'hFD, 8'h80});
        end
        drive(8'h00, 0, 0, 0, 0, 0);
    endtask

    task automatic test_hold();
        drive(8'h5A, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) tick();
        total++;
        if ({bus.X, bus.Aval, bus.Bval} !== {1'b1, 8'hFD, 8'h80}) begin
            bad++;
            $display("FAIL hold_idle got %h want %h", {bus.X, bus.Aval, bus.Bval}, {1'b1, 8'hFD, 8'h80});
        end
        // M=0 here, so a load request must not change X:A
        drive(8'h5A, 0, 0, 1, 0, 0); tick();
        total++;
        if ({bus.X, bus.Aval, bus.Bval} !== {1'b1, 8'hFD, 8'h80}) begin
            bad++;
            $display("FAIL hold_lda_m0 got %h want %h", {bus.X, bus.Aval, bus.Bval}, {1'b1, 8'hFD, 8'h80});
        end
        drive(8'h00, 0, 0, 0, 0, 0);
    endtask

    task automatic test_multiply(input logic [7:0] b, input logic [7:0] s,
                                 input logic [16:0] exp_xab, input string name);
        drive(b, 1, 0, 0, 0, 0); tick();
        drive(s, 0, 1, 0, 0, 0); tick();
        for (int i = 0; i < 8; i++) begin
            drive(s, 0, 0, 1, 0, (i == 7)); tick();
            drive(s, 0, 0, 0, 1, 0); tick();
        end
        total++;
        if ({bus.X, bus.Aval, bus.Bval} !== exp_xab) begin
            bad++;
            $display("FAIL mul_%s got %h want %h", name, {bus.X, bus.Aval, bus.Bval}, exp_xab);
        end
`ifdef MULT8_STEP_CNT_EN
        total++;
        if ({bus.Step_Cnt, bus.Done} !== {4'd8, 1'b1}) begin
            bad++;
            $display("FAIL cnt_%s got %h want %h", name, {bus.Step_Cnt, bus.Done}, {4'd8, 1'b1});
        end
`endif
        drive(8'h00, 0, 0, 0, 0, 0);
    endtask

    task automatic test_concurrent();
        preset(8'h01, 8'h01);
        drive(8'h3C, 1, 1, 0, 1, 0); tick();
        total++;
        if ({bus.X, bus.Aval, bus.Bval} !== {1'b0, 8'h00, 8'h3C}) begin
            bad++;
            $display("FAIL ldb_clr_shift got %h want %h", {bus.X, bus.Aval, bus.Bval}, {1'b0, 8'h00, 8'h3C});
        end
        preset(8'h01, 8'h01);
        drive(8'h00, 0, 1, 0, 1, 0); tick();
        total++;
        if ({bus.X, bus.Aval, bus.Bval} !== {1'b0, 8'h00, 8'h80}) begin
            bad++;
            $display("FAIL clr_shift got %h want %h", {bus.X, bus.Aval, bus.Bval}, {1'b0, 8'h00, 8'h80});
        end
        preset(8'h01, 8'h03);
        drive(8'h02, 0, 0, 1, 1, 0); tick();
        total++;
        if ({bus.X, bus.Aval, bus.Bval} !== {1'b0, 8'h03, 8'h81}) begin
            bad++;
            $display("FAIL lda_shift got %h want %h", {bus.X, bus.Aval, bus.Bval}, {1'b0, 8'h03, 8'h81});
        end
        drive(8'h00, 0, 0, 0, 0, 0);
    endtask

`ifdef MULT8_STEP_CNT_EN
    task automatic test_counter();
        drive(8'h00, 0, 0, 0, 1, 0); tick();
        total++;
        if ({bus.Step_Cnt, bus.Done} !== {4'd8, 1'b1}) begin
            bad++;
            $display("FAIL cnt_saturate got %h want %h", {bus.Step_Cnt, bus.Done}, {4'd8, 1'b1});
        end
        drive(8'h00, 0, 1, 0, 1, 0); tick();
        total++;
        if ({bus.Step_Cnt, bus.Done} !== {4'd0, 1'b0}) begin
            bad++;
            $display("FAIL cnt_clear got %h want %h", {bus.Step_Cnt, bus.Done}, {4'd0, 1'b0});
        end
        drive(8'h00, 0, 0, 0, 1, 0); tick(); tick(); tick();
        total++;
        if ({bus.Step_Cnt, bus.Done} !== {4'd3, 1'b0}) begin
            bad++;
            $display("FAIL cnt_three got %h want %h", {bus.Step_Cnt, bus.Done}, {4'd3, 1'b0});
        end
        drive(8'h00, 0, 0, 0, 0, 0);
    endtask
`endif

    task automatic test_reset_mid();
        drive(8'h07, 1, 0, 0, 0, 0); tick();
        drive(8'hFD, 0, 1, 0, 0, 0); tick();
        for (int i = 0; i < 3; i++) begin
            drive(8'hFD, 0, 0, 1, 0, 0); tick();
            drive(8'hFD, 0, 0, 0, 1, 0); tick();
        end
        Reset = 1'b0;
        drive(8'hFD, 0, 0, 0, 0, 0); tick();
        total++;
        if ({bus.X, bus.Aval, bus.Bval} !== 17'h0_0000) begin
            bad++;
            $display("FAIL reset_mid got %h want %h", {bus.X, bus.Aval, bus.Bval}, 17'h0_0000);
        end
        Reset = 1'b1;
        drive(8'h11, 1, 0, 0, 0, 0); tick();
        total++;
        if ({bus.X, bus.Aval, bus.Bval} !== {1'b0, 8'h00, 8'h11}) begin
            bad++;
            $display("FAIL post_reset_ldb got %h want %h", {bus.X, bus.Aval, bus.Bval}, {1'b0, 8'h00, 8'h11});
        end
        drive(8'h00, 0, 0, 0, 0, 0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        Reset = 1'b0;
        drive(8'h00, 0, 0, 0, 0, 0);
        test_reset();
        test_add_sub();
        test_shift();
        test_hold();
        test_multiply(8'h07, 8'hFD, {1'b1, 8'hFF, 8'hEB}, "7_x_m3");
`ifdef MULT8_STEP_CNT_EN
        test_counter();
`endif
        test_multiply(8'h80, 8'h80, {1'b0, 8'h40, 8'h00}, "m128_x_m128");
        test_multiply(8'h03, 8'h05, {1'b0, 8'h00, 8'h0F}, "3_x_5");
        test_multiply(8'h81, 8'h7F, {1'b1, 8'hC0, 8'hFF}, "m127_x_127");
        test_concurrent();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
